gact_cigar_encoder: RTL and testbench

- Sits directly downstream of GACTTop. Consumes the per-cycle traceback direction stream (dir/dir_valid) and the tile-complete pulse (done).
- Run-length encodes the stream into CIGAR-style records {op, len}. Buffers them in an internal FIFO for a ready/valid consumer, such as the host DMA packer.
- GACTTop has no backpressure on dir, so this block must absorb one direction per cycle indefinitely and flag any overflow.

---
 rtl/gact_cigar_encoder.sv | 224 ++++++++++++++++++++++
 tb/tb_gact_cigar_encoder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/gact_cigar_encoder.sv
// gact_cigar_encoder
//   Run-length encodes the GACT traceback direction stream into CIGAR-style
//   records {op, len, last}. The records are buffered in a small FIFO that a
//   ready/valid consumer drains. The block accepts one direction per cycle with
//   no backpressure toward GACTTop. Overflow and protocol errors are flagged
//   with sticky bits.
//
// Ports
//   clk               clock, all logic on posedge
//   rst               asynchronous active-low reset
//   dir, dir_valid    traceback op (1=M, 2=I, 3=D, 0=no-op) and its qualifier
//   done              one-cycle tile-complete pulse
//   rec_op/len/last   FIFO head record (forced to 0 while the FIFO is empty)
//   rec_valid         FIFO head valid
//   rec_ready         consumer accept
//   tile_ref_bases    ref bases (M+D) of the last completed tile
//   tile_query_bases  query bases (M+I) of the last completed tile
//   overflow          sticky, a record was dropped on a full FIFO
//   proto_err         sticky, dir_valid arrived while flushing
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | no pending run
// S_RUN   | run {cur_op, cur_len} accumulating
// S_FLUSH | a tile ended on an op change; emit that 1-long run as last

module gact_cigar_encoder #(
  parameter int RUN_WIDTH  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_WIDTH  = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           dir,
  input  logic                 dir_valid,
  input  logic                 done,
  output logic [1:0]           rec_op,
  output logic [RUN_WIDTH-1:0] rec_len,
  output logic                 rec_last,
  output logic                 rec_valid,
  input  logic                 rec_ready,
  output logic [CNT_WIDTH-1:0] tile_ref_bases,
  output logic [CNT_WIDTH-1:0] tile_query_bases,
  output logic                 overflow,
  output logic                 proto_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int REC_W = 2 + RUN_WIDTH + 1;

  localparam logic [1:0]           OP_M    = 2'd1;
  localparam logic [1:0]           OP_I    = 2'd2;
  localparam logic [1:0]           OP_D    = 2'd3;
  localparam logic [RUN_WIDTH-1:0] LEN_ONE = RUN_WIDTH'(1);
  localparam logic [RUN_WIDTH-1:0] LEN_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [PTR_W:0]       PTR_ONE = (PTR_W+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  state_t               state_q, state_d;
  logic [1:0]           cur_op_q, cur_op_d;
  logic [RUN_WIDTH-1:0] cur_len_q, cur_len_d;
  logic [CNT_WIDTH-1:0] ref_cnt_q, ref_cnt_d;
  logic [CNT_WIDTH-1:0] qry_cnt_q, qry_cnt_d;
  logic [CNT_WIDTH-1:0] tile_ref_q, tile_ref_d;
  logic [CNT_WIDTH-1:0] tile_qry_q, tile_qry_d;
  logic                 overflow_q, overflow_d;
  logic                 proto_err_q, proto_err_d;
  logic [PTR_W:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]       rd_ptr_q, rd_ptr_d;
  logic [REC_W-1:0]     mem_q [FIFO_DEPTH];

  logic                 dir_act;
  logic                 same_ext;
  logic                 count_dir;
  logic                 push;
  logic [REC_W-1:0]     push_rec;
  logic                 push_last;
  logic                 ref_inc, qry_inc;
  logic [CNT_WIDTH-1:0] ref_sum, qry_sum;
  logic                 fifo_empty, fifo_full;
  logic                 pop, wr_en;
  logic [REC_W-1:0]     head;

  // A valid no-op is treated exactly like an idle cycle.
  assign dir_act  = dir_valid && (dir != 2'd0);
  assign same_ext = dir_act && (dir == cur_op_q) && (cur_len_q != LEN_MAX);

  always_comb begin
    state_d     = state_q;
    cur_op_d    = cur_op_q;
    cur_len_d   = cur_len_q;
    proto_err_d = proto_err_q;
    push        = 1'b0;
    push_rec    = '0;
    count_dir   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        count_dir = dir_act;
        if (done) begin
          // A lone direction arriving with done is a complete 1-long tile.
          push     = 1'b1;
          push_rec = dir_act ? {dir, LEN_ONE, 1'b1} : {2'd0, {RUN_WIDTH{1'b0}}, 1'b1};
        end else if (dir_act) begin
          cur_op_d  = dir;
          cur_len_d = LEN_ONE;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        count_dir = dir_act;
        if (done) begin
          push = 1'b1;
          if (!dir_act) begin
            push_rec = {cur_op_q, cur_len_q, 1'b1};
            state_d  = S_IDLE;
          end else if (same_ext) begin
            push_rec = {cur_op_q, cur_len_q + LEN_ONE, 1'b1};
            state_d  = S_IDLE;
          end else begin
            // Only one push per cycle, so the new op is flushed next cycle.
            push_rec  = {cur_op_q, cur_len_q, 1'b0};
            cur_op_d  = dir;
            cur_len_d = LEN_ONE;
            state_d   = S_FLUSH;
          end
        end else if (dir_act) begin
          if (same_ext) begin
            cur_len_d = cur_len_q + LEN_ONE;
          end else begin
            push      = 1'b1;
            push_rec  = {cur_op_q, cur_len_q, 1'b0};
            cur_op_d  = dir;
            cur_len_d = LEN_ONE;
          end
        end
      end
      S_FLUSH: begin
        push     = 1'b1;
        push_rec = {cur_op_q, LEN_ONE, 1'b1};
        state_d  = S_IDLE;
        if (dir_valid) proto_err_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Per-tile base counters, saturating; the closing push snapshots them.
  assign push_last = push && push_rec[0];
  assign ref_inc   = count_dir && ((dir == OP_M) || (dir == OP_D));
  assign qry_inc   = count_dir && ((dir == OP_M) || (dir == OP_I));
  assign ref_sum   = (ref_inc && (ref_cnt_q != CNT_MAX)) ? ref_cnt_q + CNT_ONE : ref_cnt_q;
  assign qry_sum   = (qry_inc && (qry_cnt_q != CNT_MAX)) ? qry_cnt_q + CNT_ONE : qry_cnt_q;

  always_comb begin
    ref_cnt_d  = ref_sum;
    qry_cnt_d  = qry_sum;
    tile_ref_d = tile_ref_q;
    tile_qry_d = tile_qry_q;
    if (push_last) begin
      tile_ref_d = ref_sum;
      tile_qry_d = qry_sum;
      ref_cnt_d  = '0;
      qry_cnt_d  = '0;
    end
  end

  // Record FIFO: pointers carry an extra wrap bit to tell full from empty.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign pop        = !fifo_empty && rec_ready;
  // On full, a same-cycle pop frees the head slot that the push overwrites.
  assign wr_en      = push && (!fifo_full || pop);
  assign wr_ptr_d   = wr_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
  assign rd_ptr_d   = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
  assign overflow_d = overflow_q || (push && fifo_full && !pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_rec;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cur_op_q    <= 2'd0;
      cur_len_q   <= '0;
      ref_cnt_q   <= '0;
      qry_cnt_q   <= '0;
      tile_ref_q  <= '0;
      tile_qry_q  <= '0;
      overflow_q  <= 1'b0;
      proto_err_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      cur_op_q    <= cur_op_d;
      cur_len_q   <= cur_len_d;
      ref_cnt_q   <= ref_cnt_d;
      qry_cnt_q   <= qry_cnt_d;
      tile_ref_q  <= tile_ref_d;
      tile_qry_q  <= tile_qry_d;
      overflow_q  <= overflow_d;
      proto_err_q <= proto_err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  // Storage is not reset; masking the head keeps outputs at 0 while empty.
  assign head             = mem_q[rd_ptr_q[PTR_W-1:0]];
  assign rec_valid        = !fifo_empty;
  assign rec_op           = fifo_empty ? 2'd0 : head[REC_W-1 -: 2];
  assign rec_len          = fifo_empty ? '0 : head[RUN_WIDTH:1];
  assign rec_last         = fifo_empty ? 1'b0 : head[0];
  assign tile_ref_bases   = tile_ref_q;
  assign tile_query_bases = tile_qry_q;
  assign overflow         = overflow_q;
  assign proto_err        = proto_err_q;

endmodule

// File: tb/tb_gact_cigar_encoder.sv
module tb_gact_cigar_encoder;

  localparam int RW = 8;
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    dir;
  logic          dir_valid;
  logic          done;
  logic [1:0]    rec_op;
  logic [RW-1:0] rec_len;
  logic          rec_last;
  logic          rec_valid;
  logic          rec_ready;
  logic [CW-1:0] tile_ref_bases;
  logic [CW-1:0] tile_query_bases;
  logic          overflow;
  logic          proto_err;

  int n_checks = 0;
  int n_errs   = 0;
  logic [RW+2:0] exp_q[$];

  gact_cigar_encoder #(.RUN_WIDTH(RW), .FIFO_DEPTH(16), .CNT_WIDTH(CW)) dut (
    .clk              (clk),
    .rst              (rst),
    .dir              (dir),
    .dir_valid        (dir_valid),
    .done             (done),
    .rec_op           (rec_op),
    .rec_len          (rec_len),
    .rec_last         (rec_last),
    .rec_valid        (rec_valid),
    .rec_ready        (rec_ready),
    .tile_ref_bases   (tile_ref_bases),
    .tile_query_bases (tile_query_bases),
    .overflow         (overflow),
    .proto_err        (proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [RW+2:0] rec(input int op, input int len, input int last);
    return {op[1:0], len[RW-1:0], last[0]};
  endfunction

  // Scoreboard: compare the head on every accepted handshake.
  always @(negedge clk) begin
    if (rst && rec_valid && rec_ready) begin
      if (exp_q.size() == 0) chk("extra_rec", {21'd0, rec_op, rec_len, rec_last}, 32'd0);
      else chk("record", {21'd0, rec_op, rec_len, rec_last}, {21'd0, exp_q.pop_front()});
    end
  end

  task automatic step(input logic v, input logic [1:0] d, input logic dn);
    dir_valid = v;
    dir       = d;
    done      = dn;
    @(posedge clk);
    #1;
    dir_valid = 1'b0;
    dir       = 2'd0;
    done      = 1'b0;
  endtask

  task automatic run(input logic [1:0] d, input int n);
    for (int i = 0; i < n; i++) step(1'b1, d, 1'b0);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      step(1'b0, 2'd0, 1'b0);
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; dir = 2'd0; dir_valid = 1'b0; done = 1'b0; rec_ready = 1'b1;
    #3;
    chk("rst_valid", rec_valid, 0);
    chk("rst_rec", {rec_op, rec_len, rec_last}, 0);
    chk("rst_ref", tile_ref_bases, 0);
    chk("rst_qry", tile_query_bases, 0);
    chk("rst_flags", {overflow, proto_err}, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;

    // Mixed runs, done one idle cycle after the stream
    exp_q.push_back(rec(1, 5, 0));
    exp_q.push_back(rec(2, 2, 0));
    exp_q.push_back(rec(1, 3, 1));
    run(2'd1, 5); run(2'd2, 2); run(2'd1, 3);
    step(1'b0, 2'd0, 1'b0);
    step(1'b0, 2'd0, 1'b1);
    chk("t1_ref", tile_ref_bases, 8);
    chk("t1_qry", tile_query_bases, 10);
    drain();

    // Saturated run splits at 255
    exp_q.push_back(rec(1, 255, 0));
    exp_q.push_back(rec(1, 45, 1));
    run(2'd1, 300);
    step(1'b0, 2'd0, 1'b1);
    chk("t2_ref", tile_ref_bases, 300);
    chk("t2_qry", tile_query_bases, 300);
    drain();

    // Op change coinciding with done goes through FLUSH
    exp_q.push_back(rec(1, 4, 0));
    exp_q.push_back(rec(3, 1, 1));
    run(2'd1, 4);
    step(1'b1, 2'd3, 1'b1);
    step(1'b0, 2'd0, 1'b0);
    chk("t3_ref", tile_ref_bases, 5);
    chk("t3_qry", tile_query_bases, 4);
    chk("t3_perr", proto_err, 0);
    drain();

    // Empty tile marker
    exp_q.push_back(rec(0, 0, 1));
    step(1'b0, 2'd0, 1'b1);
    chk("t4_ref", tile_ref_bases, 0);
    chk("t4_qry", tile_query_bases, 0);
    drain();

    // Direction during FLUSH is dropped and flagged
    exp_q.push_back(rec(1, 1, 0));
    exp_q.push_back(rec(3, 1, 1));
    step(1'b1, 2'd1, 1'b0);
    step(1'b1, 2'd3, 1'b1);
    step(1'b1, 2'd1, 1'b0);
    chk("t5_perr", proto_err, 1);
    chk("t5_ref", tile_ref_bases, 2);
    chk("t5_qry", tile_query_bases, 1);
    drain();

    // Stalled consumer: 39 pushes into 16 entries
    rec_ready = 1'b0;
    for (int k = 0; k < 16; k++) exp_q.push_back(rec((k % 2 == 0) ? 1 : 2, 1, 0));
    for (int k = 0; k < 40; k++) step(1'b1, (k % 2 == 0) ? 2'd1 : 2'd2, 1'b0);
    chk("t6_ovf", overflow, 1);
    chk("t6_valid", rec_valid, 1);
    chk("t6_held", exp_q.size(), 16);
    rec_ready = 1'b1;
    drain();
    exp_q.push_back(rec(2, 1, 1));
    step(1'b0, 2'd0, 1'b1);
    chk("t6_ref", tile_ref_bases, 20);
    chk("t6_qry", tile_query_bases, 40);
    drain();

    // Reset mid-run discards the pending run
    run(2'd1, 7);
    rst = 1'b0;
    #1;
    chk("t7_valid", rec_valid, 0);
    chk("t7_flags", {overflow, proto_err}, 0);
    chk("t7_ref", tile_ref_bases, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.push_back(rec(2, 2, 1));
    run(2'd2, 2);
    step(1'b0, 2'd0, 1'b1);
    chk("t7_ref2", tile_ref_bases, 0);
    chk("t7_qry2", tile_query_bases, 2);
    drain();
    step(1'b0, 2'd0, 1'b0);
    chk("t7_empty", rec_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
